// File: rtl/dot_prod_pipe_if.sv
// Control/host bundle for dot_prod_pipe: start parameters, host array ports and result outputs.
// The master modport is the host side; the slave modport is the engine side.
interface dot_prod_pipe_if #(
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64,
    parameter int ADDR_W = 10
);
    logic                     r_enable;
    logic [ADDR_W-1:0]        init_i;
    logic [ADDR_W:0]          init_end;
    logic signed [ACC_W-1:0]  init_acc;
    logic                     sat_mode;
    logic                     controlArr;
    logic                     controlArrWEnable_a;
    logic                     controlArrWEnable_b;
    logic [ADDR_W-1:0]        controlArrAddr_a;
    logic [ADDR_W-1:0]        controlArrAddr_b;
    logic signed [DATA_W-1:0] controlArrWData_a;
    logic signed [DATA_W-1:0] controlArrWData_b;
    logic signed [DATA_W-1:0] controlArrRData_a;
    logic signed [DATA_W-1:0] controlArrRData_b;
    logic                     busy;
    logic                     w_enable;
    logic signed [ACC_W-1:0]  result;
    logic                     overflow;

    modport master (
        output r_enable, init_i, init_end, init_acc, sat_mode, controlArr,
               controlArrWEnable_a, controlArrWEnable_b,
               controlArrAddr_a, controlArrAddr_b,
               controlArrWData_a, controlArrWData_b,
        input  controlArrRData_a, controlArrRData_b,
               busy, w_enable, result, overflow
    );

    modport slave (
        input  r_enable, init_i, init_end, init_acc, sat_mode, controlArr,
               controlArrWEnable_a, controlArrWEnable_b,
               controlArrAddr_a, controlArrAddr_b,
               controlArrWData_a, controlArrWData_b,
        output controlArrRData_a, controlArrRData_b,
               busy, w_enable, result, overflow
    );
endinterface

// File: rtl/dot_prod_pipe.sv
// Pipelined signed dot product over two internal single-port arrays a and b,
// with wrap or saturating accumulation and host access to the arrays while idle.
module dot_prod_pipe #(
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    dot_prod_pipe_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W:0] DEPTH_END = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e state_q, state_d;

    logic                     busy;
    logic                     wEnable;
    logic                     start;
    logic                     hostOwns;
    logic [ADDR_W:0]          effEnd;
    logic [ADDR_W:0]          startCount;

    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W:0]          remain_q;
    logic [1:0]               drain_q;
    logic                     satMode_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  result_q;
    logic                     overflow_q;

    logic signed [DATA_W-1:0] memA [DEPTH];
    logic signed [DATA_W-1:0] memB [DEPTH];
    logic [ADDR_W-1:0]        addrA, addrB;
    logic                     weA, weB;
    logic                     inRangeA, inRangeB;
    logic signed [DATA_W-1:0] memA_q, memB_q;
    logic signed [DATA_W-1:0] rdA_q, rdB_q;
    logic signed [PROD_W-1:0] prod_q;
    logic                     memValid_q, rdValid_q, prodValid_q;

    logic signed [ACC_W-1:0]  prodExt;
    logic signed [ACC_W-1:0]  sumWrap;
    logic                     addOvf;

    assign start = ((state_q == IDLE) || (state_q == DONE)) && bus.r_enable;

    // Element count: end is clipped to the array depth, and an empty or inverted range gives zero.
    always_comb begin
        effEnd     = (bus.init_end > DEPTH_END) ? DEPTH_END : bus.init_end;
        startCount = '0;
        if (effEnd > {1'b0, bus.init_i}) begin
            startCount = effEnd - {1'b0, bus.init_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (startCount == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (remain_q == CNT_ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        wEnable = 1'b0;
        case (state_q)
            RUN, DRAIN: busy = 1'b1;
            DONE:       wEnable = 1'b1;
            default:    ;
        endcase
    end

    // The engine drives the array port whenever the host is locked out, so RUN never contends.
    assign hostOwns = bus.controlArr && !busy;

    always_comb begin
        addrA = addr_q;
        addrB = addr_q;
        weA   = 1'b0;
        weB   = 1'b0;
        if (hostOwns) begin
            addrA = bus.controlArrAddr_a;
            addrB = bus.controlArrAddr_b;
            weA   = bus.controlArrWEnable_a;
            weB   = bus.controlArrWEnable_b;
        end
        inRangeA = ({1'b0, addrA} < DEPTH_END);
        inRangeB = ({1'b0, addrB} < DEPTH_END);
    end

    always_ff @(posedge clk) begin
        if (weA && inRangeA) begin
            memA[addrA] <= bus.controlArrWData_a;
        end
        if (weB && inRangeB) begin
            memB[addrB] <= bus.controlArrWData_b;
        end
        memA_q <= inRangeA ? memA[addrA] : '0;
        memB_q <= inRangeB ? memB[addrB] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memValid_q  <= 1'b0;
            rdValid_q   <= 1'b0;
            prodValid_q <= 1'b0;
            rdA_q       <= '0;
            rdB_q       <= '0;
            prod_q      <= '0;
        end else begin
            memValid_q  <= (state_q == RUN);
            rdValid_q   <= memValid_q;
            prodValid_q <= rdValid_q;
            rdA_q       <= memA_q;
            rdB_q       <= memB_q;
            prod_q      <= PROD_W'(rdA_q) * PROD_W'(rdB_q);
        end
    end

    // Overflow only when both addends share a sign and the wrapped sum flips it.
    always_comb begin
        prodExt = ACC_W'(prod_q);
        sumWrap = acc_q + prodExt;
        addOvf  = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sumWrap[ACC_W-1] != acc_q[ACC_W-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            drain_q    <= 2'd0;
            satMode_q  <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else if (start) begin
            addr_q     <= bus.init_i;
            remain_q   <= startCount;
            drain_q    <= (startCount == '0) ? 2'd1 : 2'd3;
            satMode_q  <= bus.sat_mode;
            acc_q      <= bus.init_acc;
            overflow_q <= 1'b0;
        end else begin
            if (prodValid_q) begin
                if (satMode_q && addOvf) begin
                    acc_q      <= acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                    overflow_q <= 1'b1;
                end else begin
                    acc_q <= sumWrap;
                end
            end
            if (state_q == RUN) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - CNT_ONE;
            end
            if ((state_q == DRAIN) && (drain_q != 2'd0)) begin
                drain_q <= drain_q - 2'd1;
            end
            if ((state_q == DRAIN) && (state_d == DONE)) begin
                result_q <= acc_q;
            end
        end
    end

    assign bus.busy              = busy;
    assign bus.w_enable          = wEnable;
    assign bus.result            = result_q;
    assign bus.overflow          = overflow_q;
    assign bus.controlArrRData_a = hostOwns ? memA_q : '0;
    assign bus.controlArrRData_b = hostOwns ? memB_q : '0;
endmodule

// File: doc/dot_prod_pipe.md
DOT_PROD_PIPE -- requirements
Module: dot_prod_pipe

Interface
REQ-001 SHALL have parameters: DATA_W, default 27, signed element width; ACC_W, default 64, signed accumulator width, at least 2*DATA_W; DEPTH, default 1000, words per array; ADDR_W, default 10, address width, with 2^ADDR_W >= DEPTH.
REQ-002 SHALL use one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-003 Port list, as name / direction / width / meaning:
- clk / in / 1 / clock.
- rst_n / in / 1 / synchronous active-low reset.
- r_enable / in / 1 / start request, sampled in IDLE.
- init_i / in / ADDR_W / first index.
- init_end / in / ADDR_W+1 / exclusive end index.
- init_acc / in / ACC_W / signed initial accumulator.
- sat_mode / in / 1 / 0 = wrap, 1 = saturate.
- controlArr / in / 1 / host owns arrays.
- controlArrWEnable_a and controlArrWEnable_b / in / 1 / host write enable.
- controlArrAddr_a and controlArrAddr_b / in / ADDR_W / host address.
- controlArrWData_a and controlArrWData_b / in / DATA_W / host write data.
- controlArrRData_a and controlArrRData_b / out / DATA_W / host read data.
- busy / out / 1 / computation in progress.
- w_enable / out / 1 / result valid.
- result / out / ACC_W / signed dot product.
- overflow / out / 1 / sticky saturation flag.

Function
REQ-004 SHALL contain two internal single-port arrays, a and b, each DEPTH x DATA_W signed, with synchronous read: data appears the cycle after the address is presented.
REQ-005 SHALL give the host array access only when controlArr=1 and busy=0.
- Host writes land on the clock edge.
- Host reads return data one cycle after the address.
- controlArrRData_* SHALL be 0 when controlArr=0 or busy=1.
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE or DONE with r_enable=1 SHALL capture init_* and sat_mode, clear overflow and w_enable, set busy=1, and enter RUN; the edge that samples it is the start edge.
REQ-008 The effective end SHALL be min(init_end, DEPTH); N = max(0, end - init_i).
REQ-009 RUN SHALL issue address init_i+k-1 to both arrays on cycle k after the start edge, for k=1..N, one element per cycle with no stalls.
REQ-010 The datapath SHALL be pipelined:
- read data is registered;
- the full-precision 2*DATA_W signed product is registered;
- the product is sign-extended to ACC_W and added to the accumulator.
REQ-011 After the last address, RUN SHALL go to DRAIN; DRAIN SHALL last until the final accumulate completes, then go to DONE.
REQ-012 On the edge entering DONE:
- result <= accumulator;
- w_enable <= 1;
- busy <= 0.
- For N>=1 this edge SHALL be start edge + N+4.
REQ-013 For N=0, the block SHALL skip RUN, result SHALL equal init_acc, and w_enable SHALL rise at start edge + 2.
REQ-014 In DONE, w_enable and result SHALL hold until the next start or reset.
REQ-015 In wrap mode (sat_mode=0), accumulation SHALL be modulo 2^ACC_W and overflow SHALL stay 0.
REQ-016 In saturate mode (sat_mode=1), each add that exceeds the signed ACC_W range SHALL clamp to the max or min ACC_W value and set overflow; later adds continue from the clamped value.
REQ-017 r_enable while busy=1 SHALL be ignored, with no effect on the state or the running result.
REQ-018 Changing controlArr while busy=1 SHALL NOT affect the computation; the host keeps being blocked until busy=0.
REQ-019 Changing init_* or sat_mode after the start edge SHALL NOT affect the running computation.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force:
- state IDLE;
- busy=0, w_enable=0, overflow=0;
- result=0, accumulator=0.
REQ-021 Reset SHALL take priority over r_enable and may occur in any state, aborting the computation; array contents SHALL be preserved.
REQ-022 After rst_n returns to 1, the block SHALL accept a start on the next edge.

Verification
REQ-023 Load a[j]=j+1 and b[j]=2 for j<1000; start with init_i=0, init_end=1000, init_acc=0 -> result=1001000, w_enable rises at start edge + 1004.
REQ-024 Start with init_i=5, init_end=5, init_acc=-7 -> result=-7, w_enable rises at start edge + 2, no array reads.
REQ-025 Use init_end=1023 (>DEPTH) with init_i=998 and a=b=-3 at both indices -> N=2, result=init_acc+18, w_enable at start edge + 6.
REQ-026 With DATA_W=27, ACC_W=54, sat_mode=1 and all elements at -(2^26), run init_i=0, init_end=4 -> result=2^53-1, overflow=1; the same run with sat_mode=0 -> wrapped value and overflow=0.
REQ-027 Assert rst_n=0 mid-RUN, then restart -> outputs are 0 during reset; the restarted result matches a clean run; host readback shows the arrays unchanged.
REQ-028 Pulse r_enable again and drive controlArr=1 with host writes while busy -> the result is unchanged, the arrays are unwritten, and controlArrRData_*=0.
